// File: rtl/tinydec_feeder.sv
// tinydec_feeder: byte packer and word FIFO driving the TEA decoder req/ack handshake.
// Optional dec_ack watchdog enabled by defining TINYDEC_FEEDER_TIMEOUT_EN.
module tinydec_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 512
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        flush,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        dec_req,
    output logic [31:0] dec_wdata,
    input  logic        dec_ack,
    input  logic [31:0] dec_rdata,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [4:0]  level,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL = 5'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WLO, S_WHI, S_OUT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_bcnt;
    logic [23:0]   r_pack;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_level;
    logic          r_dec_req;
    logic [31:0]   r_dec_wdata;
    logic [31:0]   r_m_data;
    logic          r_m_valid;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_tmo;

    // s_ready depends only on state, never on s_valid
    assign s_ready  = rstb && ((r_bcnt != 2'd3) || (r_level != FULL));
    assign w_accept = s_valid && s_ready;
    assign w_push   = w_accept && (r_bcnt == 2'd3) && !flush;
    assign w_pop    = (r_state == S_IDLE) && (r_level != 5'd0) && dec_ack;

    assign dec_req   = r_dec_req;
    assign dec_wdata = r_dec_wdata;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_bcnt  <= 2'd0;
            r_pack  <= 24'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= 5'd0;
        end else if (flush) begin
            r_bcnt  <= 2'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= 5'd0;
        end else begin
            if (w_accept) begin
                unique case (r_bcnt)
                    2'd0:    r_pack[23:16] <= s_data;
                    2'd1:    r_pack[15:8]  <= s_data;
                    2'd2:    r_pack[7:0]   <= s_data;
                    default: ;
                endcase
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {r_pack, s_data};
    end

    // a flush never cancels the block already handed to the decoder
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state     <= S_IDLE;
            r_dec_req   <= 1'b0;
            r_dec_wdata <= 32'd0;
            r_m_data    <= 32'd0;
            r_m_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_dec_wdata <= r_mem[r_rptr];
                        r_dec_req   <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_dec_req <= 1'b0;
                    r_state   <= S_WLO;
                end
                S_WLO: begin
                    if (!dec_ack)   r_state <= S_WHI;
                    else if (w_tmo) r_state <= S_IDLE;
                end
                S_WHI: begin
                    if (dec_ack) begin
                        r_m_data  <= dec_rdata;
                        r_m_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TINYDEC_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_err;
    logic          w_wait;
    logic          w_adv;

    assign w_wait = (r_state == S_WLO) || (r_state == S_WHI);
    assign w_adv  = ((r_state == S_WLO) && !dec_ack) ||
                    ((r_state == S_WHI) && dec_ack);
    assign w_tmo  = w_wait && !w_adv &&
                    (r_tcnt == TW'(TIMEOUT - 1));
    assign err    = r_err;

    // counter restarts on every entry into a wait state
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wait && !w_adv && !w_tmo) r_tcnt <= r_tcnt + TW'(1);
            else                            r_tcnt <= '0;
            if (w_tmo) r_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_tmo            = 1'b0;
    assign err              = 1'b0;
`endif

endmodule
